// File: rtl/snes_poll_sched.sv
// rtl/snes_poll_sched.sv - dual SNES pad poll scheduler with atomic state commit
// Drives shared latch/clock, deserializes both pads, and publishes state plus edge masks.
module snes_poll_sched #(
  parameter int HALF_DIV = 300,
  parameter int POLL_DIV = 833333
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  con_serial,
  output logic        con_clock,
  output logic        con_latch,
  input  logic        auto_en,
  input  logic        poll_now,
  output logic        busy,
  output logic        state_valid,
  output logic [15:0] pad0_state,
  output logic [15:0] pad1_state,
  output logic [15:0] pad0_pressed,
  output logic [15:0] pad1_pressed,
  output logic [15:0] pad0_released,
  output logic [15:0] pad1_released
);

  localparam int HW = $clog2(2 * HALF_DIV);
  localparam int PW = $clog2(POLL_DIV);
  localparam logic [HW-1:0] LATCH_LAST  = HW'(2 * HALF_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST   = HW'(HALF_DIV - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_WAIT,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   hcnt;
  logic [3:0]      pulse;
  logic [PW-1:0]   period_cnt;
  logic [1:0]      sync_a, sync_b;
  logic [15:0]     shift0, shift1;
  logic            start;
  logic            phase_last;

  assign start = (state == S_IDLE) &&
                 (poll_now || (auto_en && (period_cnt == PERIOD_LAST)));

  always_comb begin
    phase_last = 1'b0;
    case (state)
      S_LATCH:               phase_last = (hcnt == LATCH_LAST);
      S_WAIT, S_LOW, S_HIGH: phase_last = (hcnt == HALF_LAST);
      S_DONE:                phase_last = 1'b1;
      default:               phase_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LATCH;
      S_LATCH: if (phase_last) state_nxt = S_WAIT;
      S_WAIT:  if (phase_last) state_nxt = S_LOW;
      S_LOW:   if (phase_last) state_nxt = S_HIGH;
      S_HIGH:  if (phase_last) state_nxt = (pulse == 4'd15) ? S_DONE : S_LOW;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    con_latch = 1'b0;
    con_clock = 1'b1;
    busy      = 1'b1;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_LATCH: con_latch = 1'b1;
      S_LOW:   con_clock = 1'b0;
      default: ;
    endcase
  end

  // Phase timer restarts on every state boundary; pulse index advances after each HIGH.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt  <= '0;
      pulse <= 4'd0;
    end else begin
      if (state == S_IDLE || phase_last) begin
        hcnt <= '0;
      end else begin
        hcnt <= hcnt + HW'(1);
      end
      if (state == S_IDLE) begin
        pulse <= 4'd0;
      end else if (state == S_HIGH && phase_last) begin
        pulse <= pulse + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (start || period_cnt == PERIOD_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 2'b11;
      sync_b <= 2'b11;
    end else begin
      sync_a <= con_serial;
      sync_b <= sync_a;
    end
  end

  // Bit 0 is valid as soon as the latch drops; bit p appears after rising edge p.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift0 <= '0;
      shift1 <= '0;
    end else if (state == S_WAIT && phase_last) begin
      shift0[0] <= ~sync_b[0];
      shift1[0] <= ~sync_b[1];
    end else if (state == S_HIGH && phase_last && pulse != 4'd15) begin
      shift0[pulse + 4'd1] <= ~sync_b[0];
      shift1[pulse + 4'd1] <= ~sync_b[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_valid   <= 1'b0;
      pad0_state    <= '0;
      pad1_state    <= '0;
      pad0_pressed  <= '0;
      pad1_pressed  <= '0;
      pad0_released <= '0;
      pad1_released <= '0;
    end else begin
      state_valid <= (state == S_DONE);
      if (state == S_DONE) begin
        pad0_state    <= shift0;
        pad1_state    <= shift1;
        pad0_pressed  <= shift0 & ~pad0_state;
        pad1_pressed  <= shift1 & ~pad1_state;
        pad0_released <= ~shift0 & pad0_state;
        pad1_released <= ~shift1 & pad1_state;
      end
    end
  end

endmodule

// File: tb/tb_snes_poll_sched.sv
// tb/tb_snes_poll_sched.sv - directed bench for snes_poll_sched
// Pad model shifts out a 16-bit pattern per latch; frame timing and commits are checked.
module tb_snes_poll_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  con_serial;
  logic        con_clock;
  logic        con_latch;
  logic        auto_en;
  logic        poll_now;
  logic        busy;
  logic        state_valid;
  logic [15:0] pad0_state, pad1_state;
  logic [15:0] pad0_pressed, pad1_pressed;
  logic [15:0] pad0_released, pad1_released;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] pat0 = 16'hFFFF;
  logic [15:0] pat1 = 16'hFFFF;
  logic [15:0] sh0  = 16'hFFFF;
  logic [15:0] sh1  = 16'hFFFF;
  logic        clk_prev = 1'b1;

  snes_poll_sched #(.HALF_DIV(4), .POLL_DIV(200)) dut (
    .clk           (clk),
    .reset         (reset),
    .con_serial    (con_serial),
    .con_clock     (con_clock),
    .con_latch     (con_latch),
    .auto_en       (auto_en),
    .poll_now      (poll_now),
    .busy          (busy),
    .state_valid   (state_valid),
    .pad0_state    (pad0_state),
    .pad1_state    (pad1_state),
    .pad0_pressed  (pad0_pressed),
    .pad1_pressed  (pad1_pressed),
    .pad0_released (pad0_released),
    .pad1_released (pad1_released)
  );

  always #5 clk = ~clk;

  // Pad behaviour: parallel load while latched, shift on each rising controller clock.
  always @(negedge clk) begin
    if (con_latch) begin
      sh0 = pat0;
      sh1 = pat1;
    end else if (con_clock && !clk_prev) begin
      sh0 = {1'b1, sh0[15:1]};
      sh1 = {1'b1, sh1[15:1]};
    end
    clk_prev = con_clock;
  end

  assign con_serial = {sh1[0], sh0[0]};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poll_frame(input string tag, input logic [15:0] p0, input logic [15:0] p1);
    int n, latch_cyc, low_cyc, falls;
    logic prev, busy_last;
    pat0 = p0;
    pat1 = p1;
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    check_eq({tag, "_busy_start"}, 32'(busy), 32'd1);
    n = 0; latch_cyc = 0; low_cyc = 0; falls = 0;
    prev = con_clock; busy_last = busy;
    while (!state_valid && n < 300) begin
      if (con_latch) latch_cyc++;
      if (!con_clock) low_cyc++;
      if (prev && !con_clock) falls++;
      prev = con_clock;
      busy_last = busy;
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid_delay"}, 32'(n), 32'd141);
    check_eq({tag, "_latch_cycles"}, 32'(latch_cyc), 32'd8);
    check_eq({tag, "_low_cycles"}, 32'(low_cyc), 32'd64);
    check_eq({tag, "_clock_pulses"}, 32'(falls), 32'd16);
    check_eq({tag, "_busy_in_done"}, 32'(busy_last), 32'd1);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, vcnt, falls, s1, s2;
    logic prev;
    reset = 1'b1; auto_en = 1'b0; poll_now = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_latch", 32'(con_latch), 32'd0);
    check_eq("rst_clock", 32'(con_clock), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(state_valid), 32'd0);
    check_eq("rst_pad0", 32'(pad0_state), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 1: B pressed on pad0
    poll_frame("t1", 16'hFFFE, 16'hFFFF);
    check_eq("t1_pad0_state", 32'(pad0_state), 32'h0001);
    check_eq("t1_pad0_pressed", 32'(pad0_pressed), 32'h0001);
    check_eq("t1_pad0_released", 32'(pad0_released), 32'h0000);
    check_eq("t1_pad1_state", 32'(pad1_state), 32'h0000);
    @(negedge clk);
    check_eq("t1_valid_one_cycle", 32'(state_valid), 32'd0);
    check_eq("t1_hold", 32'(pad0_state), 32'h0001);

    // 2: B released, Y pressed
    poll_frame("t2", 16'hFFFD, 16'hFFFF);
    check_eq("t2_pad0_state", 32'(pad0_state), 32'h0002);
    check_eq("t2_pad0_pressed", 32'(pad0_pressed), 32'h0002);
    check_eq("t2_pad0_released", 32'(pad0_released), 32'h0001);

    // 3: automatic polling, unchanged pattern
    auto_en = 1'b1;
    n = 0;
    while (!busy && n < 250) begin @(negedge clk); n++; end
    check_eq("t3_auto_start", 32'(busy), 32'd1);
    s1 = n;
    while (!state_valid && n < 500) begin @(negedge clk); n++; end
    check_eq("t3_valid", 32'(state_valid), 32'd1);
    check_eq("t3_pressed", 32'(pad0_pressed), 32'h0000);
    check_eq("t3_released", 32'(pad0_released), 32'h0000);
    check_eq("t3_state", 32'(pad0_state), 32'h0002);
    while (!busy && n < 700) begin @(negedge clk); n++; end
    s2 = n;
    auto_en = 1'b0;
    check_eq("t3_period", 32'(s2 - s1), 32'd200);
    n = 0;
    while (!state_valid && n < 200) begin @(negedge clk); n++; end
    check_eq("t3_second_valid", 32'(state_valid), 32'd1);
    repeat (3) @(negedge clk);

    // 4: poll_now mid-frame must be ignored
    pat0 = 16'hFFFD; pat1 = 16'h0000;
    poll_now = 1'b1;
    @(negedge clk);
    vcnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (state_valid) vcnt++;
      if (i == 140) check_eq("t4_busy_done", 32'(busy), 32'd1);
      if (i == 141) check_eq("t4_busy_low", 32'(busy), 32'd0);
      poll_now = (i == 50);
      @(negedge clk);
    end
    check_eq("t4_valid_count", 32'(vcnt), 32'd1);
    check_eq("t4_pad1_state", 32'(pad1_state), 32'hFFFF);
    check_eq("t4_pad1_pressed", 32'(pad1_pressed), 32'hFFFF);
    check_eq("t4_pad0_pressed", 32'(pad0_pressed), 32'h0000);

    // 5: reset during pulse 8
    pat0 = 16'h0F0F;
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    falls = 0; n = 0; prev = con_clock;
    while (falls < 8 && n < 200) begin
      @(negedge clk);
      n++;
      if (prev && !con_clock) falls++;
      prev = con_clock;
    end
    check_eq("t5_reached_pulse8", 32'(falls), 32'd8);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t5_clock", 32'(con_clock), 32'd1);
    check_eq("t5_latch", 32'(con_latch), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_valid", 32'(state_valid), 32'd0);
    check_eq("t5_states", {pad0_state, pad1_state}, 32'd0);
    check_eq("t5_edges", {pad1_pressed | pad0_pressed, pad1_released | pad0_released}, 32'd0);
    reset = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 199; i++) begin
      @(negedge clk);
      if (state_valid || busy) vcnt++;
    end
    check_eq("t5_no_commit", 32'(vcnt), 32'd0);

    // 6: poll_now coincides with auto expiry (counter at 199 here)
    pat0 = 16'hFFFE; pat1 = 16'hFFFF;
    auto_en = 1'b1;
    poll_now = 1'b1;
    @(negedge clk);
    auto_en = 1'b0;
    poll_now = 1'b0;
    check_eq("t6_busy", 32'(busy), 32'd1);
    vcnt = 0; s1 = 0; prev = busy;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (state_valid) vcnt++;
      if (busy && !prev) s1++;
      prev = busy;
    end
    check_eq("t6_valid_count", 32'(vcnt), 32'd1);
    check_eq("t6_extra_frames", 32'(s1), 32'd0);
    check_eq("t6_pad0_state", 32'(pad0_state), 32'h0001);
    check_eq("t6_pad0_pressed", 32'(pad0_pressed), 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
